seq_tx_serializer: RTL
======================

# seq_tx_serializer

Serial pattern transmitter for the bit-stream sequence detectors (e.g. the 1101 Moore detector). It takes a parallel frame, shifts it MSB-first onto a single-bit line, and can repeat the frame with programmable idle gaps. Its `out` drives a detector's `in` directly in system-level benches and on-board demos, and is synchronous to the same `clk`.

## Interface
- `WIDTH`, 8: maximum frame length in bits.
- `GAP`, 1: idle cycles (`out`=0) inserted between repeated frames; 0 allowed.
- `REP_W`, 4: width of the repeat-count input.
- `clk` input 1: system clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `start` input 1: request transmission; sampled only in IDLE.
- `data` input WIDTH: frame bits; bits `data[len-1:0]` are sent, MSB first.
- `len` input $clog2(WIDTH+1): frame length in bits; 0 or >WIDTH means WIDTH.
- `rep` input REP_W: extra repetitions; sends `rep+1` frames.
- `out` output 1: serial bit, registered.
- `busy` output 1: high from the first bit through the last bit of the last frame.
- `frame_end` output 1: high during the cycle carrying the last bit of each frame.
- `done` output 1: one-cycle pulse after the last bit of the last frame.

## Operation
- States: IDLE, SHIFT, GAP.
- IDLE: `out`=0, `busy`=0. If `start`=1 at a rising edge: latch `data`, effective `len` (L), and `rep` (R); go to SHIFT with `out`=`data[L-1]`, bit index L-2, repeats left R.
- SHIFT: each edge presents the next lower bit. `frame_end`=1 while bit 0 is on `out`. At the edge that ends bit 0:
  - repeats left = 0: go to IDLE, `out`=0, `done`=1 for one cycle.
  - repeats left > 0 and GAP > 0: go to GAP, `out`=0, decrement repeats left.
  - repeats left > 0 and GAP = 0: reload the latched frame, stay in SHIFT, `out`=bit L-1, decrement repeats left.
- GAP: `out`=0 for exactly GAP cycles, then reload the latched frame into SHIFT.
- `start`, `data`, `len`, and `rep` are ignored while `busy`=1. Input changes never affect a frame already in flight.
- L=1: each frame is a single cycle, and `frame_end` and the bit coincide.
- No gap follows the last frame.

## Timing
- Reset values: `out`=0, `busy`=0, `frame_end`=0, `done`=0, state IDLE. Reset is asynchronous, so asserting `rst` mid-frame clears outputs immediately and the rest of the frame is dropped.
- Latency: the first bit appears on `out` in the cycle after the edge that samples `start`.
- `busy` duration: (R+1)·L + R·GAP cycles.
- `done` is high during the first IDLE cycle. A `start` in that cycle is accepted, giving back-to-back transactions with zero dead cycles beyond the `done` cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `seq_tx_pkg` holds:
  - the state enum {IDLE, SHIFT, GAP};
  - the length-normalisation function (0/overflow → WIDTH);
  - the default constants for WIDTH, GAP, and REP_W.
- One sub-module, `seq_tx_shreg`: a loadable WIDTH-bit shift register with a bit-index counter. It provides `load`, `shift`, `bit_out`, and `last` (index = 0).
- The FSM, gap counter, and repeat counter live in the top module.

## Test plan
- Reset, then `start` with `data`=8'h0D, `len`=4, `rep`=0 → `out` = 1,1,0,1 on cycles 1–4 after the start edge. `frame_end`=1 on cycle 4, `done`=1 on cycle 5, `busy`=1 for 4 cycles.
- `data`=4'b1101, `len`=4, `rep`=2, GAP=1 → stream 1101 0 1101 0 1101, `busy`=14 cycles. When driven into the 1101 Moore detector, its `out` pulses exactly 3 times.
- GAP=0, `rep`=1, `data`=4'b1101 → 11011101. The overlapping detector reports 2 matches; `done` follows the 8th bit.
- `len`=0, `data`=8'hA5 → 8 bits 1,0,1,0,0,1,0,1 (WIDTH used).
- Pulse `start` and change `data` while `busy` → ignored, and the original frame completes unchanged. A `start` held during the `done` cycle launches a new frame next cycle.
- Assert `rst` after bit 2 of a frame → `out`, `busy`, `frame_end`, and `done` go 0 immediately. After release, there is no residual output until the next `start`.

Source files
------------

// File: rtl/seq_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_tx_pkg
// Brief    : Shared state encoding, default sizes and frame-length helper
//            for the serial pattern transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package seq_tx_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_GAP   = 1;
    localparam int DEF_REP_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // A zero or oversized length request means "send the full frame".
    function automatic int unsigned norm_len(input int unsigned len,
                                             input int unsigned width);
        return ((len == 0) || (len > width)) ? width : len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_tx_shreg.sv
`default_nettype none
// ============================================================================
// Module   : seq_tx_shreg
// Brief    : Loadable MSB-first shift register with bit-index counter and a
//            registered last-bit flag.
// Revision : 1.0 - initial release
// ============================================================================
module seq_tx_shreg #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic                       shift,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           load_data,
    input  logic [$clog2(WIDTH+1)-1:0] load_len,
    output logic                       bit_out,
    output logic                       last
);

    localparam int c_len_w = $clog2(WIDTH+1);

    logic [WIDTH-1:0]   sreg_q, sreg_d;
    logic [c_len_w-1:0] idx_q,  idx_d;
    logic               last_q, last_d;

    // Frame is left-justified on load so the serial bit is always the MSB.
    always_comb begin
        sreg_d = sreg_q;
        idx_d  = idx_q;
        last_d = last_q;
        if (clear) begin
            sreg_d = '0;
            idx_d  = '0;
            last_d = 1'b0;
        end else if (load) begin
            sreg_d = load_data << (c_len_w'(WIDTH) - load_len);
            idx_d  = load_len - c_len_w'(1);
            last_d = (load_len == c_len_w'(1));
        end else if (shift) begin
            sreg_d = sreg_q << 1;
            idx_d  = idx_q - c_len_w'(1);
            last_d = (idx_q == c_len_w'(1));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg_q <= '0;
            idx_q  <= '0;
            last_q <= 1'b0;
        end else begin
            sreg_q <= sreg_d;
            idx_q  <= idx_d;
            last_q <= last_d;
        end
    end

    assign bit_out = sreg_q[WIDTH-1];
    assign last    = last_q;

endmodule
`default_nettype wire

// File: rtl/seq_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : seq_tx_serializer
// Brief    : Serial frame transmitter with programmable repeat count and
//            idle gap between repeated frames.
// Revision : 1.0 - initial release
// ============================================================================
module seq_tx_serializer
    import seq_tx_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int GAP   = DEF_GAP,
    parameter int REP_W = DEF_REP_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [WIDTH-1:0]           data,
    input  logic [$clog2(WIDTH+1)-1:0] len,
    input  logic [REP_W-1:0]           rep,
    output logic                       out,
    output logic                       busy,
    output logic                       frame_end,
    output logic                       done
);

    localparam int c_len_w = $clog2(WIDTH+1);
    localparam int c_gap_w = (GAP > 1) ? $clog2(GAP) : 1;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   frame_q, frame_d;
    logic [c_len_w-1:0] len_q,   len_d;
    logic [REP_W-1:0]   rep_q,   rep_d;
    logic [c_gap_w-1:0] gap_q,   gap_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;

    logic               w_load, w_shift, w_clear, w_last, w_bit;
    logic [WIDTH-1:0]   w_ld_data;
    logic [c_len_w-1:0] w_ld_len, w_len_norm;

    always_comb begin
        w_len_norm = c_len_w'(norm_len(int'(len), WIDTH));
        state_d    = state_q;
        frame_d    = frame_q;
        len_d      = len_q;
        rep_d      = rep_q;
        gap_d      = gap_q;
        done_d     = 1'b0;
        w_load     = 1'b0;
        w_shift    = 1'b0;
        w_clear    = 1'b0;
        w_ld_data  = frame_q;
        w_ld_len   = len_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    w_load    = 1'b1;
                    w_ld_data = data;
                    w_ld_len  = w_len_norm;
                    frame_d   = data;
                    len_d     = w_len_norm;
                    rep_d     = rep;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!w_last) begin
                    w_shift = 1'b1;
                end else if (rep_q == '0) begin
                    w_clear = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (GAP > 0) begin
                    w_clear = 1'b1;
                    gap_d   = c_gap_w'(GAP - 1);
                    rep_d   = rep_q - REP_W'(1);
                    state_d = ST_GAP;
                end else begin
                    // Zero-gap repeat: reload straight from the latched frame.
                    w_load  = 1'b1;
                    rep_d   = rep_q - REP_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    w_load  = 1'b1;
                    state_d = ST_SHIFT;
                end else begin
                    gap_d = gap_q - c_gap_w'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            frame_q <= '0;
            len_q   <= '0;
            rep_q   <= '0;
            gap_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            len_q   <= len_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    seq_tx_shreg #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .clk       (clk),
        .rst       (rst),
        .load      (w_load),
        .shift     (w_shift),
        .clear     (w_clear),
        .load_data (w_ld_data),
        .load_len  (w_ld_len),
        .bit_out   (w_bit),
        .last      (w_last)
    );

    assign out       = w_bit;
    assign frame_end = w_last;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
`default_nettype wire
